// File: rtl/uart_tx_fifo_8n1.sv
// RS232 8N1 transmitter with a byte FIFO in front of it. The PicoBlaze output port pushes
// bytes; the FSM drains the FIFO and serialises each byte LSB first on rs232_tx.
module uart_tx_fifo_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DEPTH        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       write_tx_data,
    output logic       tx_buffer_full,
    output logic       tx_buffer_half_full,
    output logic       tx_busy,
    output logic       rs232_tx
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CountFull = CW'(DEPTH);
    localparam logic [CW-1:0] CountHalf = CW'(DEPTH / 2);
    localparam logic [BW-1:0] BaudLast  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic          push;
    logic          pop;
    logic          baud_done;
    logic          fifo_empty;

    // Push/pop qualification; a write while full is dropped even if a pop frees a slot.
    always_comb begin
        fifo_empty = (count_q == '0);
        baud_done  = (baud_q == BaudLast);
        push       = write_tx_data && !tx_buffer_full;
        pop        = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && baud_done));
    end

    assign tx_buffer_full      = (count_q == CountFull);
    assign tx_buffer_half_full = (count_q >= CountHalf);
    assign tx_busy             = (state_q != StIdle);
    assign rs232_tx            = tx_q;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data_in;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame FSM with registered line output; next level is loaded on the transition edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= '0;
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                StData: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                StStop: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            // Next byte starts with no idle gap.
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
